// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared encodings for the multi-cycle PC sequencer:
//                operation classes, SYS sub-kinds, FSM states, exception
//                cause codes and the default reset/trap vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

   // Operation class presented by decode
   typedef enum logic [2:0] {
      OP_ALU    = 3'd0,
      OP_BRANCH = 3'd1,
      OP_JUMP   = 3'd2,
      OP_JR     = 3'd3,
      OP_LOAD   = 3'd4,
      OP_STORE  = 3'd5,
      OP_MULDIV = 3'd6,
      OP_SYS    = 3'd7
   } op_class_t;

   // Sub-kind of a SYS instruction
   typedef enum logic [1:0] {
      SYS_SYSCALL = 2'd0,
      SYS_BREAK   = 2'd1,
      SYS_ERET    = 2'd2,
      SYS_RSVD    = 2'd3
   } sys_kind_t;

   // Sequencer states (value is also the debug state output)
   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_MDWAIT = 3'd5,
      ST_WB     = 3'd6,
      ST_TRAP   = 3'd7
   } state_t;

   // Exception cause codes
   localparam logic [4:0] C_CAUSE_ADEL    = 5'd4;   // misaligned JR target
   localparam logic [4:0] C_CAUSE_SYSCALL = 5'd8;
   localparam logic [4:0] C_CAUSE_BREAK   = 5'd9;
   localparam logic [4:0] C_CAUSE_RI      = 5'd10;  // reserved SYS kind
   localparam logic [4:0] C_CAUSE_MDTO    = 5'd12;  // mult/div timeout

   // Default vectors and mult/div wait limit
   localparam logic [31:0] C_RESET_VECTOR = 32'h0040_0000;
   localparam logic [31:0] C_EXC_VECTOR   = 32'h0040_0004;
   localparam int          C_MD_WAIT_MAX  = 64;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bundle of decode, memory-handshake, mult/div and PC-register
//                signals around the PC sequencer. master = sequencer side,
//                slave = surrounding datapath/memories.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
   // Inputs to the sequencer
   logic [31:0] pc_cur;
   logic        imem_ready;
   logic [2:0]  op_class;
   logic [1:0]  sys_kind;
   logic        link;
   logic        br_taken;
   logic [31:0] br_offset;
   logic [25:0] jtarget;
   logic [31:0] rs_val;
   logic [31:0] epc_in;
   logic        dmem_ready;
   logic        md_busy;
   // Outputs from the sequencer
   logic        imem_req;
   logic        ir_en;
   logic        dmem_req;
   logic        md_start;
   logic        rf_we;
   logic        pc_we;
   logic [31:0] pc_next;
   logic        epc_we;
   logic [31:0] epc_val;
   logic [4:0]  cause;
   logic [2:0]  state;

   modport master (
      input  pc_cur, imem_ready, op_class, sys_kind, link, br_taken,
             br_offset, jtarget, rs_val, epc_in, dmem_ready, md_busy,
      output imem_req, ir_en, dmem_req, md_start, rf_we, pc_we, pc_next,
             epc_we, epc_val, cause, state
   );

   modport slave (
      output pc_cur, imem_ready, op_class, sys_kind, link, br_taken,
             br_offset, jtarget, rs_val, epc_in, dmem_ready, md_busy,
      input  imem_req, ir_en, dmem_req, md_start, rf_we, pc_we, pc_next,
             epc_we, epc_val, cause, state
   );
endinterface
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : npc_calc
//  Description : Combinational next-PC generator. All arithmetic wraps
//                modulo 2^32. For SYS the only PC-writing case is eret, so
//                the SYS target is the saved EPC.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_calc
   import cpu_ctrl_pkg::*;
(
   input  logic [31:0] pc_cur,
   input  logic [2:0]  op_class,
   input  logic        br_taken,
   input  logic [31:0] br_offset,
   input  logic [25:0] jtarget,
   input  logic [31:0] rs_val,
   input  logic [31:0] epc_in,
   output logic [31:0] pc_next
);

   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = pc_cur + 32'd4;

   // Select the target for the current operation class
   always_comb begin
      pc_next = w_pc_plus4;
      case (op_class)
         OP_BRANCH: pc_next = br_taken ? (w_pc_plus4 + br_offset) : w_pc_plus4;
         OP_JUMP:   pc_next = {w_pc_plus4[31:28], jtarget, 2'b00};
         OP_JR:     pc_next = rs_val;
         OP_SYS:    pc_next = epc_in;
         default:   pc_next = w_pc_plus4;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Multi-cycle control FSM owning the PC register write enable
//                and next-PC value. Steps each instruction through
//                fetch/decode/execute/memory/writeback, raises traps and
//                handles eret. Exactly one pc_we pulse per instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = C_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = C_EXC_VECTOR,
   parameter int          MD_WAIT_MAX  = C_MD_WAIT_MAX
)(
   input  logic           clk,
   input  logic           rst,      // asynchronous, active-low
   pc_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(MD_WAIT_MAX + 1);

   state_t             r_state;
   logic               r_is_store;
   logic [4:0]         r_cause;
   logic [CNT_W-1:0]   r_md_cnt;

   logic [2:0]         w_npc_op;
   logic [31:0]        w_npc;
   logic               w_jr_aligned;

   assign w_jr_aligned = (bus.rs_val[1:0] == 2'b00);

   // Outside EXEC only the sequential target (pc+4) is ever written, so the
   // generator is steered to the ALU case there regardless of op_class.
   assign w_npc_op = (r_state == ST_EXEC) ? bus.op_class : OP_ALU;

   npc_calc u_npc_calc (
      .pc_cur    (bus.pc_cur),
      .op_class  (w_npc_op),
      .br_taken  (bus.br_taken),
      .br_offset (bus.br_offset),
      .jtarget   (bus.jtarget),
      .rs_val    (bus.rs_val),
      .epc_in    (bus.epc_in),
      .pc_next   (w_npc)
   );

   // State sequencing, trap cause capture and mult/div wait counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_RESET;
         r_is_store <= 1'b0;
         r_cause    <= 5'd0;
         r_md_cnt   <= '0;
      end else begin
         case (r_state)
            ST_RESET:  r_state <= ST_FETCH;
            ST_FETCH:  if (bus.imem_ready) r_state <= ST_DECODE;
            ST_DECODE: r_state <= ST_EXEC;
            ST_EXEC: begin
               r_md_cnt <= '0;
               case (bus.op_class)
                  OP_ALU:    r_state <= ST_WB;
                  OP_BRANCH: r_state <= ST_FETCH;
                  OP_JUMP:   r_state <= ST_FETCH;
                  OP_JR: begin
                     if (w_jr_aligned) begin
                        r_state <= ST_FETCH;
                     end else begin
                        r_state <= ST_TRAP;
                        r_cause <= C_CAUSE_ADEL;
                     end
                  end
                  OP_LOAD: begin
                     r_state    <= ST_MEM;
                     r_is_store <= 1'b0;
                  end
                  OP_STORE: begin
                     r_state    <= ST_MEM;
                     r_is_store <= 1'b1;
                  end
                  OP_MULDIV: r_state <= ST_MDWAIT;
                  default: begin // OP_SYS
                     case (bus.sys_kind)
                        SYS_SYSCALL: begin
                           r_state <= ST_TRAP;
                           r_cause <= C_CAUSE_SYSCALL;
                        end
                        SYS_BREAK: begin
                           r_state <= ST_TRAP;
                           r_cause <= C_CAUSE_BREAK;
                        end
                        SYS_ERET: r_state <= ST_FETCH;
                        default: begin
                           r_state <= ST_TRAP;
                           r_cause <= C_CAUSE_RI;
                        end
                     endcase
                  end
               endcase
            end
            ST_MEM: begin
               if (bus.dmem_ready) r_state <= r_is_store ? ST_FETCH : ST_WB;
            end
            ST_MDWAIT: begin
               if (!bus.md_busy) begin
                  r_state <= ST_FETCH;
               end else if (r_md_cnt == CNT_W'(MD_WAIT_MAX - 1)) begin
                  r_state <= ST_TRAP;
                  r_cause <= C_CAUSE_MDTO;
               end else begin
                  r_md_cnt <= r_md_cnt + 1'b1;
               end
            end
            ST_WB:   r_state <= ST_FETCH;
            default: r_state <= ST_FETCH; // ST_TRAP
         endcase
      end
   end

   // Output decode from the registered state, qualified by handshakes; the
   // async reset forces ST_RESET so every strobe drops immediately.
   always_comb begin
      bus.imem_req = 1'b0;
      bus.ir_en    = 1'b0;
      bus.dmem_req = 1'b0;
      bus.md_start = 1'b0;
      bus.rf_we    = 1'b0;
      bus.pc_we    = 1'b0;
      bus.epc_we   = 1'b0;
      bus.epc_val  = 32'd0;
      bus.pc_next  = w_npc;
      case (r_state)
         ST_RESET: bus.pc_next = RESET_VECTOR;
         ST_FETCH: begin
            bus.imem_req = 1'b1;
            bus.ir_en    = bus.imem_ready;
         end
         ST_EXEC: begin
            case (bus.op_class)
               OP_BRANCH: bus.pc_we = 1'b1;
               OP_JUMP: begin
                  bus.pc_we = 1'b1;
                  bus.rf_we = bus.link;
               end
               OP_JR: begin
                  bus.pc_we = w_jr_aligned;
                  bus.rf_we = w_jr_aligned & bus.link;
               end
               OP_MULDIV: bus.md_start = 1'b1;
               OP_SYS:    bus.pc_we = (bus.sys_kind == SYS_ERET);
               default: ;
            endcase
         end
         ST_MEM: begin
            bus.dmem_req = 1'b1;
            bus.pc_we    = r_is_store & bus.dmem_ready;
         end
         ST_MDWAIT: bus.pc_we = ~bus.md_busy;
         ST_WB: begin
            bus.rf_we = 1'b1;
            bus.pc_we = 1'b1;
         end
         ST_TRAP: begin
            bus.epc_we  = 1'b1;
            bus.epc_val = bus.pc_cur;
            bus.pc_next = EXC_VECTOR;
            bus.pc_we   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.cause = r_cause;
   assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Directed instructions
//                push their expected PC-update into a queue; a monitor pops
//                and compares on every pc_we pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
   import cpu_ctrl_pkg::*;

   localparam logic [31:0] RV = 32'h0040_0000;
   localparam logic [31:0] EV = 32'h0040_0004;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_VECTOR (RV),
      .EXC_VECTOR   (EV),
      .MD_WAIT_MAX  (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] pc_next;
      logic        rf_we;
      logic        epc_we;
      logic [4:0]  cause;
      logic [31:0] epc_val;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endfunction

   // Monitor: every PC update must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && bus.pc_we === 1'b1) begin
         if (q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_pc_we: pc_we=1 pc_next=%h with nothing pending", bus.pc_next);
         end else begin
            e = q.pop_front();
            chk("pc_next", bus.pc_next, e.pc_next);
            chk("rf_we", 32'(bus.rf_we), 32'(e.rf_we));
            chk("epc_we", 32'(bus.epc_we), 32'(e.epc_we));
            if (e.epc_we) begin
               chk("cause", 32'(bus.cause), 32'(e.cause));
               chk("epc_val", bus.epc_val, e.epc_val);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [2:0] op, input logic [1:0] sk, input logic lk,
                            input logic bt, input logic [31:0] pc, input logic [31:0] off,
                            input logic [25:0] jt, input logic [31:0] rs, input logic [31:0] epc);
      bus.op_class  = op;
      bus.sys_kind  = sk;
      bus.link      = lk;
      bus.br_taken  = bt;
      bus.pc_cur    = pc;
      bus.br_offset = off;
      bus.jtarget   = jt;
      bus.rs_val    = rs;
      bus.epc_in    = epc;
   endtask

   task automatic push(input logic [31:0] pn, input logic rf, input logic ew,
                       input logic [4:0] c, input logic [31:0] ev);
      exp_t e;
      e.pc_next = pn;
      e.rf_we   = rf;
      e.epc_we  = ew;
      e.cause   = c;
      e.epc_val = ev;
      q.push_back(e);
   endtask

   task automatic run_to_pcwe(input string name, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (bus.pc_we === 1'b1) done = 1'b1;
         tick();
      end
      n_total++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s: no pc_we within %0d cycles", name, budget);
      end
   endtask

   task automatic do_instr(input string name, input logic [2:0] op, input logic [1:0] sk,
                           input logic lk, input logic bt, input logic [31:0] pc,
                           input logic [31:0] off, input logic [25:0] jt, input logic [31:0] rs,
                           input logic [31:0] epc, input logic [31:0] x_pn, input logic x_rf,
                           input logic x_ew, input logic [4:0] x_c, input logic [31:0] x_ev);
      set_instr(op, sk, lk, bt, pc, off, jt, rs, epc);
      push(x_pn, x_rf, x_ew, x_c, x_ev);
      run_to_pcwe(name, 100);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  req, req_at_we, starts, busy_n, mdw, pcwe_cnt;
      bit  done, seen;

      rst            = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b1;
      bus.md_busy    = 1'b0;
      set_instr(OP_ALU, 2'd0, 1'b0, 1'b0, RV, 32'd0, 26'd0, 32'd0, 32'd0);

      // ---- 1. reset state, then a plain ALU instruction
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", 32'(bus.state), 32'(ST_RESET));
      chk("rst_pc_next", bus.pc_next, RV);
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      chk("rst_md_start", 32'(bus.md_start), 32'd0);
      chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_epc_we", 32'(bus.epc_we), 32'd0);
      chk("rst_cause", 32'(bus.cause), 32'd0);
      chk("rst_epc_val", bus.epc_val, 32'd0);
      tick();
      rst            = 1'b1;
      bus.imem_ready = 1'b1;
      push(32'h0040_0004, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      @(negedge clk);
      chk("t1_fetch_state", 32'(bus.state), 32'(ST_FETCH));
      chk("t1_imem_req", 32'(bus.imem_req), 32'd1);
      chk("t1_ir_en", 32'(bus.ir_en), 32'd1);
      tick();
      @(negedge clk);
      chk("t1_decode_state", 32'(bus.state), 32'(ST_DECODE));
      chk("t1_decode_ir_en", 32'(bus.ir_en), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_exec_state", 32'(bus.state), 32'(ST_EXEC));
      tick();
      run_to_pcwe("t1_alu_wb", 3);

      // ---- 2. branches, jumps, JR, wrap, load
      do_instr("br_taken", OP_BRANCH, 2'd0, 1'b0, 1'b1, 32'h0040_0010, 32'hFFFF_FFF0, 26'd0, 32'd0, 32'd0,
               32'h0040_0004, 1'b0, 1'b0, 5'd0, 32'd0);
      do_instr("br_not_taken", OP_BRANCH, 2'd0, 1'b0, 1'b0, 32'h0040_0010, 32'hFFFF_FFF0, 26'd0, 32'd0, 32'd0,
               32'h0040_0014, 1'b0, 1'b0, 5'd0, 32'd0);
      do_instr("jal", OP_JUMP, 2'd0, 1'b1, 1'b0, 32'h0040_0030, 32'd0, 26'h010_0040, 32'd0, 32'd0,
               32'h0040_0100, 1'b1, 1'b0, 5'd0, 32'd0);
      do_instr("j_high", OP_JUMP, 2'd0, 1'b0, 1'b0, 32'h9000_0010, 32'd0, 26'h3FF_FFFF, 32'd0, 32'd0,
               32'h9FFF_FFFC, 1'b0, 1'b0, 5'd0, 32'd0);
      do_instr("jalr", OP_JR, 2'd0, 1'b1, 1'b0, 32'h0040_0034, 32'd0, 26'd0, 32'h0040_0200, 32'd0,
               32'h0040_0200, 1'b1, 1'b0, 5'd0, 32'd0);
      do_instr("alu_wrap", OP_ALU, 2'd0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 26'd0, 32'd0, 32'd0,
               32'h0000_0000, 1'b1, 1'b0, 5'd0, 32'd0);
      do_instr("load", OP_LOAD, 2'd0, 1'b0, 1'b0, 32'h0040_0038, 32'd0, 26'd0, 32'd0, 32'd0,
               32'h0040_003C, 1'b1, 1'b0, 5'd0, 32'd0);

      // ---- 3. store with dmem_ready held low for 5 MEM cycles
      set_instr(OP_STORE, 2'd0, 1'b0, 1'b0, 32'h0040_0040, 32'd0, 26'd0, 32'd0, 32'd0);
      bus.dmem_ready = 1'b0;
      push(32'h0040_0044, 1'b0, 1'b0, 5'd0, 32'd0);
      req = 0; req_at_we = 0; done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (bus.dmem_req === 1'b1) req++;
         if (bus.pc_we === 1'b1) begin
            done = 1'b1;
            req_at_we = req;
         end
         tick();
         if (req == 5) bus.dmem_ready = 1'b1;
      end
      chk("store_dmem_req_cycles", req, 32'd6);
      chk("store_pc_we_cycle", req_at_we, 32'd6);

      // ---- 4. mult/div: 10 busy cycles, zero-wait, and stuck busy
      set_instr(OP_MULDIV, 2'd0, 1'b0, 1'b0, 32'h0040_0050, 32'd0, 26'd0, 32'd0, 32'd0);
      push(32'h0040_0054, 1'b0, 1'b0, 5'd0, 32'd0);
      starts = 0; busy_n = 0; mdw = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.md_start === 1'b1) starts++;
         if (bus.state === ST_MDWAIT) mdw++;
         if (bus.pc_we === 1'b1) done = 1'b1;
         tick();
         if (starts > 0 && busy_n < 10) begin
            bus.md_busy = 1'b1;
            busy_n++;
         end else begin
            bus.md_busy = 1'b0;
         end
      end
      chk("md_start_pulses", starts, 32'd1);
      chk("md_wait_cycles", mdw, 32'd11);
      do_instr("md_zero_wait", OP_MULDIV, 2'd0, 1'b0, 1'b0, 32'h0040_0058, 32'd0, 26'd0, 32'd0, 32'd0,
               32'h0040_005C, 1'b0, 1'b0, 5'd0, 32'd0);
      bus.md_busy = 1'b1;
      do_instr("md_timeout", OP_MULDIV, 2'd0, 1'b0, 1'b0, 32'h0040_0060, 32'd0, 26'd0, 32'd0, 32'd0,
               EV, 1'b0, 1'b1, 5'd12, 32'h0040_0060);
      bus.md_busy = 1'b0;

      // ---- 5. traps and eret
      do_instr("syscall", OP_SYS, 2'd0, 1'b0, 1'b0, 32'h0040_0020, 32'd0, 26'd0, 32'd0, 32'd0,
               EV, 1'b0, 1'b1, 5'd8, 32'h0040_0020);
      do_instr("break", OP_SYS, 2'd1, 1'b0, 1'b0, 32'h0040_0028, 32'd0, 26'd0, 32'd0, 32'd0,
               EV, 1'b0, 1'b1, 5'd9, 32'h0040_0028);
      do_instr("eret", OP_SYS, 2'd2, 1'b0, 1'b0, 32'h0040_0004, 32'd0, 26'd0, 32'd0, 32'h0040_0024,
               32'h0040_0024, 1'b0, 1'b0, 5'd0, 32'd0);
      do_instr("sys_reserved", OP_SYS, 2'd3, 1'b0, 1'b0, 32'h0040_002C, 32'd0, 26'd0, 32'd0, 32'd0,
               EV, 1'b0, 1'b1, 5'd10, 32'h0040_002C);
      do_instr("jr_misaligned", OP_JR, 2'd0, 1'b1, 1'b0, 32'h0040_0030, 32'd0, 26'd0, 32'h0040_0002, 32'd0,
               EV, 1'b0, 1'b1, 5'd4, 32'h0040_0030);

      // ---- 6. async reset in the middle of a stalled store
      set_instr(OP_STORE, 2'd0, 1'b0, 1'b0, 32'h0040_0070, 32'd0, 26'd0, 32'd0, 32'd0);
      bus.dmem_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.state === ST_MEM) seen = 1'b1;
         else tick();
      end
      chk("t6_reached_mem", 32'(seen), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("t6_dmem_req_drop", 32'(bus.dmem_req), 32'd0);
      chk("t6_pc_we_drop", 32'(bus.pc_we), 32'd0);
      chk("t6_state_reset", 32'(bus.state), 32'(ST_RESET));
      chk("t6_pc_next_reset", bus.pc_next, RV);
      tick();
      tick();
      rst            = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b1;
      rst            = 1'b1;
      set_instr(OP_ALU, 2'd0, 1'b0, 1'b0, 32'h0040_0080, 32'd0, 26'd0, 32'd0, 32'd0);
      tick();
      pcwe_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.pc_we === 1'b1) pcwe_cnt++;
         tick();
      end
      chk("t6_no_pc_we_after_release", pcwe_cnt, 32'd0);
      @(negedge clk);
      chk("t6_fetch_state", 32'(bus.state), 32'(ST_FETCH));
      chk("t6_imem_req_held", 32'(bus.imem_req), 32'd1);
      chk("t6_ir_en_wait", 32'(bus.ir_en), 32'd0);
      tick();
      bus.imem_ready = 1'b1;
      push(32'h0040_0084, 1'b1, 1'b0, 5'd0, 32'd0);
      run_to_pcwe("t6_recover_alu", 20);

      repeat (3) tick();
      chk("queue_drained", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
